// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: write/select, scoreboard, clear control and packed read ports.
interface reg_file_mp_if #(
  parameter int A     = 4,
  parameter int W     = 8,
  parameter int NREAD = 2
);
  logic             Write_En;
  logic [1:0]       Src_Sel;
  logic [A-1:0]     Wr_Addr;
  logic [W-1:0]     ALU_Input;
  logic [W-1:0]     Acc_Input;
  logic [W-1:0]     Mem_Input;
  logic [NREAD*A-1:0] Rd_Addr;
  logic [NREAD*W-1:0] DataOut;
  logic [NREAD-1:0] Ready;
  logic             Pend_Set;
  logic [A-1:0]     Pend_Addr;
  logic             Clear_Req;
  logic             Clear_Busy;
  logic             Clear_Done;

  modport master (
    output Write_En, Src_Sel, Wr_Addr, ALU_Input, Acc_Input, Mem_Input,
           Rd_Addr, Pend_Set, Pend_Addr, Clear_Req,
    input  DataOut, Ready, Clear_Busy, Clear_Done
  );

  modport slave (
    input  Write_En, Src_Sel, Wr_Addr, ALU_Input, Acc_Input, Mem_Input,
           Rd_Addr, Pend_Set, Pend_Addr, Clear_Req,
    output DataOut, Ready, Clear_Busy, Clear_Done
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file with pending-load scoreboard and sequenced bulk clear.
// Optional write-through forwarding on read ports: define REGFILE_BYPASS_EN.
module reg_file_mp #(
  parameter int A     = 4,
  parameter int W     = 8,
  parameter int NREAD = 2
) (
  input logic          clk,
  input logic          Reset,
  reg_file_mp_if.slave bus
);
  localparam int unsigned N = 2 ** A;

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t       state, state_nxt;
  logic [W-1:0] regs [N];
  logic [N-1:0] pend;
  logic [A-1:0] idx;
  logic         busy, done;
  logic         wr_commit;
  logic [W-1:0] wr_data;

  always_comb begin
    wr_data = '0;
    case (bus.Src_Sel)
      2'b00:   wr_data = bus.ALU_Input;
      2'b01:   wr_data = bus.Acc_Input;
      2'b10:   wr_data = bus.Mem_Input;
      default: wr_data = '0;
    endcase
  end

  assign wr_commit = bus.Write_En && (bus.Src_Sel != 2'b11) && (state == IDLE);

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (bus.Clear_Req) state_nxt = CLEAR;
      CLEAR: begin
        busy = 1'b1;
        if (idx == '1) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.Clear_Busy = busy;
  assign bus.Clear_Done = done;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Index only advances in CLEAR; holding it at zero elsewhere covers the load on entry.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset)               idx <= '0;
    else if (state == CLEAR) idx <= idx + A'(1);
    else                     idx <= '0;
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < N; i++) regs[i[A-1:0]] <= '0;
      pend <= '0;
    end else if (state == CLEAR) begin
      regs[idx] <= '0;
      pend[idx] <= 1'b0;
    end else if (state == IDLE) begin
      if (wr_commit) regs[bus.Wr_Addr] <= wr_data;
      if (wr_commit && bus.Src_Sel == 2'b10) pend[bus.Wr_Addr] <= 1'b0;
      // Later assignment wins, so a same-cycle re-issue keeps the bit set.
      if (bus.Pend_Set) pend[bus.Pend_Addr] <= 1'b1;
    end
  end

  always_comb begin
    logic [A-1:0] ra;
    ra          = '0;
    bus.DataOut = '0;
    bus.Ready   = '0;
    for (int unsigned k = 0; k < NREAD; k++) begin
      ra = bus.Rd_Addr[k*A +: A];
      bus.DataOut[k*W +: W] = regs[ra];
      bus.Ready[k]          = !pend[ra] && !busy;
`ifdef REGFILE_BYPASS_EN
      if (wr_commit && !Reset && ra == bus.Wr_Addr) begin
        bus.DataOut[k*W +: W] = wr_data;
        if (bus.Src_Sel == 2'b10 && !(bus.Pend_Set && bus.Pend_Addr == ra))
          bus.Ready[k] = 1'b1;
      end
`endif
    end
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed scenarios plus random traffic against an array model.
module tb_reg_file_mp;
  localparam int A = 4, W = 8, NREAD = 2, N = 16;

  logic clk = 1'b0;
  logic Reset = 1'b1;
  always #5 clk = ~clk;

  reg_file_mp_if #(.A(A), .W(W), .NREAD(NREAD)) bus();
  reg_file_mp #(.A(A), .W(W), .NREAD(NREAD)) dut (.clk(clk), .Reset(Reset), .bus(bus));

  int total = 0;
  int bad = 0;

  logic [W-1:0] m_regs [N];
  bit           m_pend [N];
  int           phase;   // 0 idle, 1..N clearing register phase-1, N+1 done pulse

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] m_src();
    case (bus.Src_Sel)
      2'd0:    return bus.ALU_Input;
      2'd1:    return bus.Acc_Input;
      default: return bus.Mem_Input;
    endcase
  endfunction

  function automatic bit m_commit();
    return bus.Write_En && bus.Src_Sel != 2'd3 && phase == 0 && !Reset;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
    phase = 0;
  endtask

  task automatic check_outputs();
    logic [A-1:0] ra;
    logic [W-1:0] ed;
    bit           er;
    for (int k = 0; k < NREAD; k++) begin
      ra = bus.Rd_Addr[k*A +: A];
      ed = m_regs[ra];
      er = !m_pend[ra] && phase == 0;
`ifdef REGFILE_BYPASS_EN
      if (m_commit() && bus.Wr_Addr == ra) begin
        ed = m_src();
        if (bus.Src_Sel == 2'd2 && !(bus.Pend_Set && bus.Pend_Addr == ra)) er = 1'b1;
      end
`endif
      check($sformatf("data%0d_r%0d", k, ra), 32'(bus.DataOut[k*W +: W]), 32'(ed));
      check($sformatf("ready%0d_r%0d", k, ra), 32'(bus.Ready[k]), 32'(er));
    end
    check("busy", 32'(bus.Clear_Busy), 32'(phase != 0));
    check("done", 32'(bus.Clear_Done), 32'(phase == N + 1));
  endtask

  task automatic model_edge();
    if (phase == 0) begin
      if (m_commit()) begin
        m_regs[bus.Wr_Addr] = m_src();
        if (bus.Src_Sel == 2'd2) m_pend[bus.Wr_Addr] = 1'b0;
      end
      if (bus.Pend_Set) m_pend[bus.Pend_Addr] = 1'b1;
      if (bus.Clear_Req) phase = 1;
    end else if (phase <= N) begin
      m_regs[phase-1] = '0;
      m_pend[phase-1] = 1'b0;
      phase++;
    end else begin
      phase = 0;
    end
  endtask

  task automatic tick();
    #3;
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    bus.Write_En  = 1'b0;
    bus.Src_Sel   = 2'd3;
    bus.Wr_Addr   = '0;
    bus.ALU_Input = '0;
    bus.Acc_Input = '0;
    bus.Mem_Input = '0;
    bus.Pend_Set  = 1'b0;
    bus.Pend_Addr = '0;
    bus.Clear_Req = 1'b0;
  endtask

  task automatic set_rd(input logic [A-1:0] a0, input logic [A-1:0] a1);
    bus.Rd_Addr = {a1, a0};
  endtask

  task automatic wr(input logic [1:0] src, input logic [A-1:0] addr, input logic [W-1:0] d);
    bus.Write_En  = 1'b1;
    bus.Src_Sel   = src;
    bus.Wr_Addr   = addr;
    bus.ALU_Input = W'($urandom);
    bus.Acc_Input = W'($urandom);
    bus.Mem_Input = W'($urandom);
    case (src)
      2'd0:    bus.ALU_Input = d;
      2'd1:    bus.Acc_Input = d;
      default: bus.Mem_Input = d;
    endcase
  endtask

  task automatic async_reset();
    idle_inputs();
    #2;
    Reset = 1'b1;
    #1;
    m_reset();
    check_outputs();
    check("rst_data", 32'(bus.DataOut), 32'h0);
    check("rst_ready", 32'(bus.Ready), 32'h3);
    @(posedge clk);
    #1;
    Reset = 1'b0;
  endtask

  task automatic run_clear(input bit inject);
    int busy_cnt;
    int done_at;
    busy_cnt = 0;
    done_at  = 0;
    idle_inputs();
    bus.Clear_Req = 1'b1;
    tick();
    bus.Clear_Req = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      idle_inputs();
      set_rd(4'd2, 4'(c));
      if (inject && c == 3) wr(2'd0, 4'd2, 8'hAA);
      #1;
      if (bus.Clear_Busy) busy_cnt++;
      if (bus.Clear_Done) done_at = c;
      tick();
      if (busy_cnt > 0 && phase == 0 && !bus.Clear_Busy) break;
    end
    check("clear_busy_cycles", 32'(busy_cnt), 32'd17);
    check("clear_done_cycle", 32'(done_at), 32'd17);
  endtask

  task automatic sweep_zero();
    idle_inputs();
    for (int i = 0; i < N; i++) begin
      set_rd(4'(i), 4'(N - 1 - i));
      #1;
      check($sformatf("zero_r%0d", i), 32'(bus.DataOut[W-1:0]), 32'h0);
      tick();
    end
  endtask

  initial begin
    m_reset();
    idle_inputs();
    set_rd(4'd0, 4'd1);
    #3;
    check_outputs();
    check("rst_ready0", 32'(bus.Ready), 32'h3);
    @(posedge clk);
    #1;
    Reset = 1'b0;

    wr(2'd0, 4'd3, 8'h5A); tick();
    wr(2'd1, 4'd4, 8'hC3); tick();
    idle_inputs(); set_rd(4'd3, 4'd4); tick();
    check("r4r3", 32'(bus.DataOut), 32'hC35A);
    wr(2'd3, 4'd3, 8'h00); bus.ALU_Input = 8'h00; tick();
    idle_inputs(); tick();
    check("nowrite_r3", 32'(bus.DataOut[W-1:0]), 32'h5A);

    set_rd(4'd5, 4'd3);
    wr(2'd0, 4'd5, 8'h77); tick();
    idle_inputs(); tick();
    check("r5_next", 32'(bus.DataOut[W-1:0]), 32'h77);

    async_reset();
    wr(2'd0, 4'd3, 8'h5A); tick();

    idle_inputs(); set_rd(4'd7, 4'd3);
    bus.Pend_Set = 1'b1; bus.Pend_Addr = 4'd7; tick();
    idle_inputs(); tick();
    check("pend7_ready", 32'(bus.Ready[0]), 32'h0);
    wr(2'd2, 4'd7, 8'h11); tick();
    idle_inputs(); tick();
    check("mem7_ready", 32'(bus.Ready[0]), 32'h1);
    check("mem7_data", 32'(bus.DataOut[W-1:0]), 32'h11);
    wr(2'd2, 4'd7, 8'h22); bus.Pend_Set = 1'b1; bus.Pend_Addr = 4'd7; tick();
    idle_inputs(); tick();
    check("setwins_ready", 32'(bus.Ready[0]), 32'h0);

    for (int i = 0; i < N; i++) begin
      wr(2'd0, 4'(i), 8'hFF); tick();
    end
    run_clear(1'b1);
    sweep_zero();

    for (int i = 0; i < N; i++) begin
      wr(2'd1, 4'(i), 8'(i * 7 + 1)); tick();
    end
    idle_inputs(); bus.Clear_Req = 1'b1; tick();
    idle_inputs();
    for (int c = 0; c < 20 && phase != 6; c++) tick();
    check("midclear_phase", 32'(phase), 32'd6);
    async_reset();
    check("midclear_busy", 32'(bus.Clear_Busy), 32'h0);
    sweep_zero();
    run_clear(1'b0);

    for (int c = 0; c < 400; c++) begin
      bus.Write_En  = 1'($urandom);
      bus.Src_Sel   = 2'($urandom);
      bus.Wr_Addr   = 4'($urandom);
      bus.ALU_Input = 8'($urandom);
      bus.Acc_Input = 8'($urandom);
      bus.Mem_Input = 8'($urandom);
      bus.Rd_Addr   = 8'($urandom);
      bus.Pend_Set  = ($urandom_range(0, 3) == 0);
      bus.Pend_Addr = 4'($urandom);
      bus.Clear_Req = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0) bus.Rd_Addr[A-1:0] = bus.Wr_Addr;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
